// File: rtl/traffic_ctrl_pkg.sv
// Shared types and constants for the traffic light controller:
// phase encodings, lamp patterns and default phase durations.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED1      = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED2      = 3'd5
  } state_e;

  // Lamp vectors are ordered {R,Y,G}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int GREEN_S_DEF     = 30;
  localparam int YELLOW_S_DEF    = 3;
  localparam int RED_S_DEF       = 2;
  localparam int PED_MIN_S_DEF   = 5;
  localparam int TICKS_PER_S_DEF = 10;

  function automatic state_e nextState(input state_e s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return RED1;
      RED1:      return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return RED2;
      default:   return NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_tick_sync.sv
// Two-flop synchronizer plus rising-edge detector for a slow asynchronous input.
// The edge detector stays disarmed until the synchronizer holds real input data.
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] vld_q;

  // prev_q starts high so a level already high at reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b1;
      vld_q  <= 2'b00;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      vld_q  <= {vld_q[0], 1'b1};
      if (vld_q[1]) prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/traffic_ctrl.sv
// Two-way intersection controller with all-red clearance and pedestrian request
// shortening of green; timing is driven by a sampled 100 ms square wave.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_S     = GREEN_S_DEF,
  parameter int YELLOW_S    = YELLOW_S_DEF,
  parameter int RED_S       = RED_S_DEF,
  parameter int PED_MIN_S   = PED_MIN_S_DEF,
  parameter int TICKS_PER_S = TICKS_PER_S_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk100ms,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] sec_left,
  output logic [2:0] phase
);

  localparam int SUBW = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(TICKS_PER_S - 1);

  logic            tick;
  logic            pedRise;
  logic            isGreen;

  state_e          state_q,   state_d;
  logic [7:0]      secLeft_q, secLeft_d;
  logic [SUBW-1:0] subtick_q, subtick_d;
  logic            pedPend_q, pedPend_d;
  logic [2:0]      nsLamp_q,  nsLamp_d;
  logic [2:0]      ewLamp_q,  ewLamp_d;

  tick_sync u_tickSync (
    .clk     (clk),
    .rst     (rst),
    .async_i (clk100ms),
    .rise_o  (tick)
  );

  tick_sync u_pedSync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ped_req),
    .rise_o  (pedRise)
  );

  function automatic logic [7:0] durationOf(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   return 8'(GREEN_S);
      NS_YELLOW, EW_YELLOW: return 8'(YELLOW_S);
      default:              return 8'(RED_S);
    endcase
  endfunction

  assign isGreen = (state_q == NS_GREEN) || (state_q == EW_GREEN);

  // Pedestrian forcing takes priority over the second countdown on the same tick
  always_comb begin
    state_d   = state_q;
    secLeft_d = secLeft_q;
    subtick_d = subtick_q;
    pedPend_d = pedPend_q | pedRise;
    if (tick) begin
      if (isGreen && pedPend_d && (secLeft_q > 8'(PED_MIN_S))) begin
        secLeft_d = 8'(PED_MIN_S);
        subtick_d = '0;
      end else if (subtick_q == SUB_LAST) begin
        subtick_d = '0;
        if (secLeft_q > 8'd1) begin
          secLeft_d = secLeft_q - 8'd1;
        end else begin
          state_d   = nextState(state_q);
          secLeft_d = durationOf(state_d);
          if (isGreen) pedPend_d = pedRise;
        end
      end else begin
        subtick_d = subtick_q + SUBW'(1);
      end
    end
  end

  always_comb begin
    nsLamp_d = LAMP_R;
    ewLamp_d = LAMP_R;
    case (state_d)
      NS_GREEN:  nsLamp_d = LAMP_G;
      NS_YELLOW: nsLamp_d = LAMP_Y;
      EW_GREEN:  ewLamp_d = LAMP_G;
      EW_YELLOW: ewLamp_d = LAMP_Y;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NS_GREEN;
      secLeft_q <= 8'(GREEN_S);
      subtick_q <= '0;
      pedPend_q <= 1'b0;
      nsLamp_q  <= LAMP_G;
      ewLamp_q  <= LAMP_R;
    end else begin
      state_q   <= state_d;
      secLeft_q <= secLeft_d;
      subtick_q <= subtick_d;
      pedPend_q <= pedPend_d;
      nsLamp_q  <= nsLamp_d;
      ewLamp_q  <= ewLamp_d;
    end
  end

  assign ns_light = nsLamp_q;
  assign ew_light = ewLamp_q;
  assign sec_left = secLeft_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed testbench for traffic_ctrl with short durations
// (TICKS_PER_S=2, GREEN_S=4, YELLOW_S=2, RED_S=1, PED_MIN_S=2).
module tb_traffic_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk100ms = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [7:0] sec_left;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;

  int         expTicks [6] = '{8, 4, 2, 8, 4, 2};
  int         expDur   [6] = '{4, 2, 1, 4, 2, 1};
  logic [2:0] expNs    [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] expEw    [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  traffic_ctrl #(
    .GREEN_S     (4),
    .YELLOW_S    (2),
    .RED_S       (1),
    .PED_MIN_S   (2),
    .TICKS_PER_S (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk100ms (clk100ms),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .sec_left (sec_left),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // One 100 ms period compressed to 8 clocks; ends on a falling edge
  task doTick;
    @(negedge clk) clk100ms = 1'b1;
    repeat (4) @(negedge clk);
    clk100ms = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task pulsePed;
    @(negedge clk) ped_req = 1'b1;
    repeat (4) @(negedge clk);
    ped_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task doReset;
    @(negedge clk);
    rst = 1'b1;
    clk100ms = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (phase !== 3'd0) begin fails++; $display("[TB] FAIL reset_phase: got %0d want 0", phase); end
    tests++; if (sec_left !== 8'd4) begin fails++; $display("[TB] FAIL reset_sec: got %0d want 4", sec_left); end
    tests++; if (ns_light !== 3'b001 || ew_light !== 3'b100) begin fails++; $display("[TB] FAIL reset_lamps: got ns=%b ew=%b want ns=001 ew=100", ns_light, ew_light); end
    tests++; if (int'(dut.subtick_q) != 0) begin fails++; $display("[TB] FAIL reset_subtick: got %0d want 0", dut.subtick_q); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    doTick();
    tests++; if (sec_left !== 8'd4 || int'(dut.subtick_q) != 1) begin fails++; $display("[TB] FAIL first_tick: got sec=%0d sub=%0d want sec=4 sub=1", sec_left, dut.subtick_q); end
    tests++; if (ns_light !== 3'b001 || ew_light !== 3'b100) begin fails++; $display("[TB] FAIL first_tick_lamps: got ns=%b ew=%b want ns=001 ew=100", ns_light, ew_light); end
  endtask

  task test_full_cycle;
    int cnt;
    doReset();
    for (int p = 0; p < 6; p++) begin
      cnt = 0;
      tests++; if (ns_light !== expNs[p] || ew_light !== expEw[p]) begin fails++; $display("[TB] FAIL cycle_lamps p%0d: got ns=%b ew=%b want ns=%b ew=%b", p, ns_light, ew_light, expNs[p], expEw[p]); end
      while (phase === 3'(p) && cnt < 20) begin
        tests++; if (sec_left !== 8'(expDur[p] - cnt / 2)) begin fails++; $display("[TB] FAIL cycle_sec p%0d t%0d: got %0d want %0d", p, cnt, sec_left, expDur[p] - cnt / 2); end
        doTick();
        cnt++;
      end
      tests++; if (cnt != expTicks[p]) begin fails++; $display("[TB] FAIL cycle_ticks p%0d: got %0d want %0d", p, cnt, expTicks[p]); end
      tests++; if (phase !== 3'((p + 1) % 6)) begin fails++; $display("[TB] FAIL cycle_next p%0d: got %0d want %0d", p, phase, (p + 1) % 6); end
    end
  endtask

  task test_ped_ns_green;
    doReset();
    pulsePed();
    tests++; if (sec_left !== 8'd4) begin fails++; $display("[TB] FAIL ped_ns_hold: got %0d want 4", sec_left); end
    doTick();
    tests++; if (sec_left !== 8'd2 || int'(dut.subtick_q) != 0) begin fails++; $display("[TB] FAIL ped_ns_force: got sec=%0d sub=%0d want sec=2 sub=0", sec_left, dut.subtick_q); end
    repeat (3) doTick();
    tests++; if (phase !== NS_GREEN || sec_left !== 8'd1) begin fails++; $display("[TB] FAIL ped_ns_count: got ph=%0d sec=%0d want ph=0 sec=1", phase, sec_left); end
    doTick();
    tests++; if (phase !== NS_YELLOW || sec_left !== 8'd2) begin fails++; $display("[TB] FAIL ped_ns_yellow: got ph=%0d sec=%0d want ph=1 sec=2", phase, sec_left); end
    tests++; if (dut.pedPend_q !== 1'b0) begin fails++; $display("[TB] FAIL ped_ns_clear: got %b want 0", dut.pedPend_q); end
  endtask

  task test_ped_red1;
    doReset();
    repeat (12) doTick();
    tests++; if (phase !== RED1 || sec_left !== 8'd1) begin fails++; $display("[TB] FAIL red1_reach: got ph=%0d sec=%0d want ph=2 sec=1", phase, sec_left); end
    pulsePed();
    tests++; if (dut.pedPend_q !== 1'b1) begin fails++; $display("[TB] FAIL red1_pend: got %b want 1", dut.pedPend_q); end
    doTick();
    tests++; if (phase !== RED1 || sec_left !== 8'd1) begin fails++; $display("[TB] FAIL red1_hold: got ph=%0d sec=%0d want ph=2 sec=1", phase, sec_left); end
    doTick();
    tests++; if (phase !== EW_GREEN || sec_left !== 8'd4) begin fails++; $display("[TB] FAIL red1_ewg: got ph=%0d sec=%0d want ph=3 sec=4", phase, sec_left); end
    doTick();
    tests++; if (sec_left !== 8'd2 || int'(dut.subtick_q) != 0) begin fails++; $display("[TB] FAIL red1_force: got sec=%0d sub=%0d want sec=2 sub=0", sec_left, dut.subtick_q); end
    repeat (4) doTick();
    tests++; if (phase !== EW_YELLOW || dut.pedPend_q !== 1'b0) begin fails++; $display("[TB] FAIL red1_ewy: got ph=%0d pend=%b want ph=4 pend=0", phase, dut.pedPend_q); end
  endtask

  task test_reset_midyellow;
    doReset();
    repeat (23) doTick();
    @(negedge clk) clk100ms = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (phase !== EW_YELLOW || sec_left !== 8'd1) begin fails++; $display("[TB] FAIL midy_reach: got ph=%0d sec=%0d want ph=4 sec=1", phase, sec_left); end
    rst = 1'b1;
    #1;
    tests++; if (phase !== NS_GREEN || sec_left !== 8'd4) begin fails++; $display("[TB] FAIL midy_async: got ph=%0d sec=%0d want ph=0 sec=4", phase, sec_left); end
    tests++; if (ns_light !== 3'b001 || ew_light !== 3'b100) begin fails++; $display("[TB] FAIL midy_lamps: got ns=%b ew=%b want ns=001 ew=100", ns_light, ew_light); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests++; if (int'(dut.subtick_q) != 0 || sec_left !== 8'd4) begin fails++; $display("[TB] FAIL midy_notick: got sec=%0d sub=%0d want sec=4 sub=0", sec_left, dut.subtick_q); end
    clk100ms = 1'b0;
    repeat (4) @(negedge clk);
    doTick();
    tests++; if (int'(dut.subtick_q) != 1 || sec_left !== 8'd4) begin fails++; $display("[TB] FAIL midy_newtick: got sec=%0d sub=%0d want sec=4 sub=1", sec_left, dut.subtick_q); end
  endtask

  task test_aligned;
    doReset();
    repeat (3) doTick();
    tests++; if (sec_left !== 8'd3 || int'(dut.subtick_q) != 1) begin fails++; $display("[TB] FAIL align_setup: got sec=%0d sub=%0d want sec=3 sub=1", sec_left, dut.subtick_q); end
    @(negedge clk);
    clk100ms = 1'b1;
    ped_req = 1'b1;
    repeat (4) @(negedge clk);
    clk100ms = 1'b0;
    ped_req = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (sec_left !== 8'd2 || int'(dut.subtick_q) != 0) begin fails++; $display("[TB] FAIL align_force: got sec=%0d sub=%0d want sec=2 sub=0", sec_left, dut.subtick_q); end
    doTick();
    tests++; if (sec_left !== 8'd2 || int'(dut.subtick_q) != 1) begin fails++; $display("[TB] FAIL align_nomore: got sec=%0d sub=%0d want sec=2 sub=1", sec_left, dut.subtick_q); end
    doTick();
    tests++; if (sec_left !== 8'd1 || phase !== NS_GREEN) begin fails++; $display("[TB] FAIL align_count: got sec=%0d ph=%0d want sec=1 ph=0", sec_left, phase); end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_ped_ns_green();
    test_ped_red1();
    test_reset_midyellow();
    test_aligned();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
